// File: rtl/mips_ctrl_ext.sv
// Single-cycle MIPS main decoder with immediate and sub-word load extenders.
// Decode is combinational; only the sticky illegal-instruction flag is registered.
module mips_ctrl_ext (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic [15:0] Imm16,
  input  logic [7:0]  LoadByte,
  input  logic [15:0] LoadHalf,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        ALUasrc,
  output logic        RegWrite,
  output logic        EXTOP,
  output logic [3:0]  ALUOp,
  output logic [1:0]  NPCOP,
  output logic        ShiftIndex,
  output logic        ShiftDirection,
  output logic        SArith,
  output logic        call,
  output logic        SpLoad,
  output logic        BorH,
  output logic        SorU,
  output logic        SpecialIn,
  output logic        DMemBorH,
  output logic [31:0] Imm32,
  output logic [31:0] ByteExt,
  output logic [31:0] HalfExt,
  output logic        Illegal,
  output logic        IllegalSeen
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_NOR   = 4'b0101,
    ALU_SLT   = 4'b0110,
    ALU_SLTU  = 4'b0111,
    ALU_LUI   = 4'b1000,
    ALU_PASSA = 4'b1001,
    ALU_ADDU  = 4'b1010,
    ALU_SUBU  = 4'b1011
  } aluOp_e;

  aluOp_e      aluOp;
  logic        regWriteD;
  logic        memWriteD;
  logic        memReadD;
  logic [1:0]  npcOpD;

  always_comb begin
    RegDst         = 1'b0;
    memReadD       = 1'b0;
    MemtoReg       = 1'b0;
    memWriteD      = 1'b0;
    ALUSrc         = 1'b0;
    ALUasrc        = 1'b0;
    regWriteD      = 1'b0;
    EXTOP          = 1'b0;
    aluOp          = ALU_ADD;
    npcOpD         = 2'b00;
    ShiftIndex     = 1'b0;
    ShiftDirection = 1'b0;
    SArith         = 1'b0;
    call           = 1'b0;
    SpLoad         = 1'b0;
    BorH           = 1'b0;
    SorU           = 1'b0;
    SpecialIn      = 1'b0;
    DMemBorH       = 1'b0;
    Illegal        = 1'b0;

    case (Opcode)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            RegDst    = 1'b1;
            regWriteD = 1'b1;
            case (Funct)
              6'h21:   aluOp = ALU_ADDU;
              6'h22:   aluOp = ALU_SUB;
              6'h23:   aluOp = ALU_SUBU;
              6'h24:   aluOp = ALU_AND;
              6'h25:   aluOp = ALU_OR;
              6'h26:   aluOp = ALU_XOR;
              6'h27:   aluOp = ALU_NOR;
              6'h2A:   aluOp = ALU_SLT;
              6'h2B:   aluOp = ALU_SLTU;
              default: aluOp = ALU_ADD;
            endcase
          end
          // Funct[2] picks the variable-amount form, Funct[1] right, Funct[0] arithmetic.
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
            RegDst         = 1'b1;
            regWriteD      = 1'b1;
            ALUasrc        = 1'b1;
            aluOp          = ALU_PASSA;
            ShiftIndex     = Funct[2];
            ShiftDirection = Funct[1];
            SArith         = Funct[0];
          end
          6'h08: npcOpD = 2'b11;
          6'h09: begin
            npcOpD    = 2'b11;
            call      = 1'b1;
            regWriteD = 1'b1;
          end
          default: Illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        ALUSrc    = 1'b1;
        regWriteD = 1'b1;
        EXTOP     = (Opcode[3:2] == 2'b10);
        case (Opcode)
          6'h09:   aluOp = ALU_ADDU;
          6'h0A:   aluOp = ALU_SLT;
          6'h0B:   aluOp = ALU_SLTU;
          6'h0C:   aluOp = ALU_AND;
          6'h0D:   aluOp = ALU_OR;
          6'h0E:   aluOp = ALU_XOR;
          6'h0F:   aluOp = ALU_LUI;
          default: aluOp = ALU_ADD;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        ALUSrc    = 1'b1;
        EXTOP     = 1'b1;
        memReadD  = 1'b1;
        MemtoReg  = 1'b1;
        regWriteD = 1'b1;
        SpLoad    = (Opcode != 6'h23);
        BorH      = (Opcode == 6'h21) || (Opcode == 6'h25);
        SorU      = (Opcode == 6'h20) || (Opcode == 6'h21);
      end
      6'h28, 6'h29, 6'h2B: begin
        ALUSrc    = 1'b1;
        EXTOP     = 1'b1;
        memWriteD = 1'b1;
        SpecialIn = (Opcode != 6'h2B);
        DMemBorH  = (Opcode == 6'h29);
      end
      6'h04: begin
        EXTOP  = 1'b1;
        aluOp  = ALU_SUB;
        npcOpD = Zero ? 2'b01 : 2'b00;
      end
      6'h05: begin
        EXTOP  = 1'b1;
        aluOp  = ALU_SUB;
        npcOpD = Zero ? 2'b00 : 2'b01;
      end
      6'h02: npcOpD = 2'b10;
      6'h03: begin
        npcOpD    = 2'b10;
        call      = 1'b1;
        regWriteD = 1'b1;
      end
      default: Illegal = 1'b1;
    endcase
  end

  // State-changing controls are held off while reset is asserted.
  assign ALUOp    = aluOp;
  assign RegWrite = regWriteD & ~rst;
  assign MemWrite = memWriteD & ~rst;
  assign MemRead  = memReadD  & ~rst;
  assign NPCOP    = rst ? 2'b00 : npcOpD;

  assign Imm32   = EXTOP ? {{16{Imm16[15]}}, Imm16}  : {16'h0000, Imm16};
  assign ByteExt = SorU  ? {{24{LoadByte[7]}}, LoadByte} : {24'h000000, LoadByte};
  assign HalfExt = SorU  ? {{16{LoadHalf[15]}}, LoadHalf} : {16'h0000, LoadHalf};

  always_ff @(posedge clk) begin
    if (rst) IllegalSeen <= 1'b0;
    else     IllegalSeen <= IllegalSeen | Illegal;
  end

endmodule

// File: tb/tb_mips_ctrl_ext.sv
// Bench for mips_ctrl_ext: directed vector table, sticky-flag sequences and
// random instructions checked against a rule-table reference model.
module tb_mips_ctrl_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Opcode, Funct;
  logic        Zero;
  logic [15:0] Imm16, LoadHalf;
  logic [7:0]  LoadByte;
  logic        RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, ALUasrc, RegWrite, EXTOP;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOP;
  logic        ShiftIndex, ShiftDirection, SArith, call, SpLoad, BorH, SorU;
  logic        SpecialIn, DMemBorH, Illegal, IllegalSeen;
  logic [31:0] Imm32, ByteExt, HalfExt;

  always #5 clk = ~clk;

  mips_ctrl_ext dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Imm16(Imm16), .LoadByte(LoadByte), .LoadHalf(LoadHalf),
    .RegDst(RegDst), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .ALUasrc(ALUasrc), .RegWrite(RegWrite), .EXTOP(EXTOP),
    .ALUOp(ALUOp), .NPCOP(NPCOP), .ShiftIndex(ShiftIndex),
    .ShiftDirection(ShiftDirection), .SArith(SArith), .call(call),
    .SpLoad(SpLoad), .BorH(BorH), .SorU(SorU), .SpecialIn(SpecialIn),
    .DMemBorH(DMemBorH), .Imm32(Imm32), .ByteExt(ByteExt), .HalfExt(HalfExt),
    .Illegal(Illegal), .IllegalSeen(IllegalSeen)
  );

  typedef struct packed {
    logic       regDst, memRead, memtoReg, memWrite, aluSrc, aluAsrc, regWrite, extOp;
    logic [3:0] aluOp;
    logic [1:0] npcOp;
    logic       shiftIndex, shiftDir, sArith, call, spLoad, borH, sorU;
    logic       specialIn, dmemBorH, illegal;
  } ctrl_t;

  typedef struct {
    logic        r;
    logic [5:0]  op, fn;
    logic        z;
    logic [15:0] imm;
    logic [7:0]  lb;
    logic [15:0] lh;
    ctrl_t       exp;
    logic [31:0] expImm, expByte, expHalf;
  } vec_t;

  ctrl_t got;
  assign got = {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, ALUasrc, RegWrite, EXTOP,
                ALUOp, NPCOP, ShiftIndex, ShiftDirection, SArith, call, SpLoad, BorH,
                SorU, SpecialIn, DMemBorH, Illegal};

  int unsigned checks = 0;
  int unsigned failures = 0;
  vec_t  vecs[$];
  ctrl_t c;
  ctrl_t rules [bit [11:0]];
  logic  seenM;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s op=%h fn=%h rst=%b got=%h expected=%h", name, Opcode, Funct, rst, act, req);
    end
  endtask

  task automatic addVec(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic [15:0] imm, input logic [7:0] lb, input logic [15:0] lh,
                        input ctrl_t e, input logic [31:0] ei, input logic [31:0] eb,
                        input logic [31:0] eh);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.imm = imm; v.lb = lb; v.lh = lh;
    v.exp = e; v.expImm = ei; v.expByte = eb; v.expHalf = eh;
    vecs.push_back(v);
  endtask

  // Instruction-class templates for the reference rule table.
  function automatic ctrl_t rt(input logic [3:0] a);
    ctrl_t t = '0;
    t.regDst = 1; t.regWrite = 1; t.aluOp = a;
    return t;
  endfunction
  function automatic ctrl_t sh(input logic idx, input logic dir, input logic ar);
    ctrl_t t = rt(4'b1001);
    t.aluAsrc = 1; t.shiftIndex = idx; t.shiftDir = dir; t.sArith = ar;
    return t;
  endfunction
  function automatic ctrl_t it(input logic [3:0] a, input logic ext);
    ctrl_t t = '0;
    t.aluSrc = 1; t.regWrite = 1; t.extOp = ext; t.aluOp = a;
    return t;
  endfunction
  function automatic ctrl_t ld(input logic sp, input logic bh, input logic su);
    ctrl_t t = '0;
    t.aluSrc = 1; t.extOp = 1; t.memRead = 1; t.memtoReg = 1; t.regWrite = 1;
    t.spLoad = sp; t.borH = bh; t.sorU = su;
    return t;
  endfunction
  function automatic ctrl_t st(input logic sp, input logic bh);
    ctrl_t t = '0;
    t.aluSrc = 1; t.extOp = 1; t.memWrite = 1; t.specialIn = sp; t.dmemBorH = bh;
    return t;
  endfunction

  task automatic buildRules();
    ctrl_t t;
    rules[{6'h00, 6'h20}] = rt(4'b0000); rules[{6'h00, 6'h21}] = rt(4'b1010);
    rules[{6'h00, 6'h22}] = rt(4'b0001); rules[{6'h00, 6'h23}] = rt(4'b1011);
    rules[{6'h00, 6'h24}] = rt(4'b0010); rules[{6'h00, 6'h25}] = rt(4'b0011);
    rules[{6'h00, 6'h26}] = rt(4'b0100); rules[{6'h00, 6'h27}] = rt(4'b0101);
    rules[{6'h00, 6'h2A}] = rt(4'b0110); rules[{6'h00, 6'h2B}] = rt(4'b0111);
    rules[{6'h00, 6'h00}] = sh(0, 0, 0); rules[{6'h00, 6'h02}] = sh(0, 1, 0);
    rules[{6'h00, 6'h03}] = sh(0, 1, 1); rules[{6'h00, 6'h04}] = sh(1, 0, 0);
    rules[{6'h00, 6'h06}] = sh(1, 1, 0); rules[{6'h00, 6'h07}] = sh(1, 1, 1);
    t = '0; t.npcOp = 2'b11;                             rules[{6'h00, 6'h08}] = t;
    t = '0; t.npcOp = 2'b11; t.call = 1; t.regWrite = 1; rules[{6'h00, 6'h09}] = t;
    rules[{6'h08, 6'h00}] = it(4'b0000, 1); rules[{6'h09, 6'h00}] = it(4'b1010, 1);
    rules[{6'h0A, 6'h00}] = it(4'b0110, 1); rules[{6'h0B, 6'h00}] = it(4'b0111, 1);
    rules[{6'h0C, 6'h00}] = it(4'b0010, 0); rules[{6'h0D, 6'h00}] = it(4'b0011, 0);
    rules[{6'h0E, 6'h00}] = it(4'b0100, 0); rules[{6'h0F, 6'h00}] = it(4'b1000, 0);
    rules[{6'h23, 6'h00}] = ld(0, 0, 0); rules[{6'h20, 6'h00}] = ld(1, 0, 1);
    rules[{6'h24, 6'h00}] = ld(1, 0, 0); rules[{6'h21, 6'h00}] = ld(1, 1, 1);
    rules[{6'h25, 6'h00}] = ld(1, 1, 0);
    rules[{6'h2B, 6'h00}] = st(0, 0); rules[{6'h28, 6'h00}] = st(1, 0);
    rules[{6'h29, 6'h00}] = st(1, 1);
    t = '0; t.extOp = 1; t.aluOp = 4'b0001; rules[{6'h04, 6'h00}] = t; rules[{6'h05, 6'h00}] = t;
    t = '0; t.npcOp = 2'b10;                             rules[{6'h02, 6'h00}] = t;
    t = '0; t.npcOp = 2'b10; t.call = 1; t.regWrite = 1; rules[{6'h03, 6'h00}] = t;
  endtask

  function automatic ctrl_t model(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                  input logic z);
    bit [11:0] k = (op == 6'h00) ? {op, fn} : {op, 6'h00};
    ctrl_t m;
    if (rules.exists(k)) m = rules[k];
    else begin m = '0; m.illegal = 1; end
    if (op == 6'h04) m.npcOp = z ? 2'b01 : 2'b00;
    if (op == 6'h05) m.npcOp = z ? 2'b00 : 2'b01;
    if (r) begin m.regWrite = 0; m.memWrite = 0; m.memRead = 0; m.npcOp = 2'b00; end
    return m;
  endfunction

  function automatic logic [31:0] ext(input logic [15:0] v, input int unsigned w, input logic sgn);
    int signed s = (w == 8) ? int'($signed(v[7:0])) : int'($signed(v));
    int unsigned u = (w == 8) ? int'(v[7:0]) : int'(v);
    return sgn ? 32'(s) : 32'(u);
  endfunction

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [15:0] imm, input logic [7:0] lb, input logic [15:0] lh);
    rst = r; Opcode = op; Funct = fn; Zero = z; Imm16 = imm; LoadByte = lb; LoadHalf = lh;
  endtask

  logic [5:0] legalOps [0:20] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                  6'h0F, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B, 6'h28,
                                  6'h29, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] legalFns [0:17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                  6'h08, 6'h09};

  initial begin
    buildRules();
    drive(1, 6'h00, 6'h20, 0, 16'h0, 8'h0, 16'h0);

    c = '0; c.aluSrc = 1; c.extOp = 1;
    addVec(1, 6'h2B, 6'h00, 0, 16'h8004, 8'h7F, 16'h1234, c, 32'hFFFF8004, 32'h0000007F, 32'h00001234);
    c = '0; c.regDst = 1; c.regWrite = 1; c.aluAsrc = 1; c.shiftDir = 1; c.sArith = 1; c.aluOp = 4'b1001;
    addVec(0, 6'h00, 6'h03, 0, 16'h1234, 8'h80, 16'h8000, c, 32'h00001234, 32'h00000080, 32'h00008000);
    c.shiftIndex = 1;
    addVec(0, 6'h00, 6'h07, 1, 16'h1234, 8'h80, 16'h8000, c, 32'h00001234, 32'h00000080, 32'h00008000);
    c = '0; c.extOp = 1; c.aluOp = 4'b0001; c.npcOp = 2'b01;
    addVec(0, 6'h04, 6'h00, 1, 16'hFFFF, 8'h00, 16'h0000, c, 32'hFFFFFFFF, 32'h0, 32'h0);
    addVec(0, 6'h05, 6'h00, 0, 16'hFFFF, 8'h00, 16'h0000, c, 32'hFFFFFFFF, 32'h0, 32'h0);
    c.npcOp = 2'b00;
    addVec(0, 6'h04, 6'h00, 0, 16'hFFFF, 8'h00, 16'h0000, c, 32'hFFFFFFFF, 32'h0, 32'h0);
    addVec(0, 6'h05, 6'h00, 1, 16'hFFFF, 8'h00, 16'h0000, c, 32'hFFFFFFFF, 32'h0, 32'h0);
    c = '0; c.aluSrc = 1; c.regWrite = 1; c.aluOp = 4'b0011;
    addVec(0, 6'h0D, 6'h00, 0, 16'h8000, 8'h00, 16'h0000, c, 32'h00008000, 32'h0, 32'h0);
    c = '0; c.aluSrc = 1; c.regWrite = 1; c.extOp = 1;
    addVec(0, 6'h08, 6'h00, 0, 16'h8000, 8'h00, 16'h0000, c, 32'hFFFF8000, 32'h0, 32'h0);
    c = '0; c.aluSrc = 1; c.extOp = 1; c.memRead = 1; c.memtoReg = 1; c.regWrite = 1;
    c.spLoad = 1; c.sorU = 1;
    addVec(0, 6'h20, 6'h00, 0, 16'h0010, 8'h80, 16'h8001, c, 32'h00000010, 32'hFFFFFF80, 32'hFFFF8001);
    c.sorU = 0; c.borH = 1;
    addVec(0, 6'h25, 6'h00, 0, 16'h0004, 8'h80, 16'h8001, c, 32'h00000004, 32'h00000080, 32'h00008001);
    c = '0; c.call = 1; c.regWrite = 1; c.npcOp = 2'b10;
    addVec(0, 6'h03, 6'h00, 0, 16'h8000, 8'h00, 16'h0000, c, 32'h00008000, 32'h0, 32'h0);
    c.regWrite = 0; c.npcOp = 2'b00;
    addVec(1, 6'h03, 6'h00, 0, 16'h8000, 8'h00, 16'h0000, c, 32'h00008000, 32'h0, 32'h0);
    c = '0; c.call = 1; c.regWrite = 1; c.npcOp = 2'b11;
    addVec(0, 6'h00, 6'h09, 1, 16'h0000, 8'h00, 16'h0000, c, 32'h0, 32'h0, 32'h0);
    c = '0; c.illegal = 1;
    addVec(0, 6'h3F, 6'h00, 1, 16'h8000, 8'hFF, 16'hFFFF, c, 32'h00008000, 32'h000000FF, 32'h0000FFFF);
    addVec(0, 6'h00, 6'h01, 1, 16'h8000, 8'hFF, 16'hFFFF, c, 32'h00008000, 32'h000000FF, 32'h0000FFFF);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].imm, vecs[i].lb, vecs[i].lh);
      #1;
      chk("vec_ctrl", 32'(got), 32'(vecs[i].exp));
      chk("vec_imm32", Imm32, vecs[i].expImm);
      chk("vec_byteext", ByteExt, vecs[i].expByte);
      chk("vec_halfext", HalfExt, vecs[i].expHalf);
    end

    // Sticky flag: reset clears it, one illegal cycle sets it, only reset clears it again.
    @(negedge clk); drive(1, 6'h2B, 6'h00, 0, 16'h0, 8'h0, 16'h0);
    @(posedge clk); #1 chk("seen_reset", 32'(IllegalSeen), 32'd0);
    @(negedge clk); drive(0, 6'h3F, 6'h00, 0, 16'h0, 8'h0, 16'h0);
    #1 chk("seen_comb_illegal", 32'(Illegal), 32'd1);
    chk("seen_before_edge", 32'(IllegalSeen), 32'd0);
    @(posedge clk); #1 chk("seen_set", 32'(IllegalSeen), 32'd1);
    @(negedge clk); drive(0, 6'h00, 6'h20, 0, 16'h0, 8'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 chk("seen_sticky", 32'(IllegalSeen), 32'd1);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1 chk("seen_cleared", 32'(IllegalSeen), 32'd0);

    seenM = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op, fn;
      logic r;
      ctrl_t e;
      op = ($urandom_range(3) != 0) ? legalOps[$urandom_range(20)] : 6'($urandom);
      fn = ($urandom_range(3) != 0) ? legalFns[$urandom_range(17)] : 6'($urandom);
      r  = ($urandom_range(15) == 0);
      @(negedge clk);
      drive(r, op, fn, 1'($urandom), 16'($urandom), 8'($urandom), 16'($urandom));
      #1;
      e = model(r, op, fn, Zero);
      chk("rnd_ctrl", 32'(got), 32'(e));
      chk("rnd_imm32", Imm32, ext(Imm16, 16, e.extOp));
      chk("rnd_byteext", ByteExt, ext({8'h00, LoadByte}, 8, e.sorU));
      chk("rnd_halfext", HalfExt, ext(LoadHalf, 16, e.sorU));
      @(posedge clk);
      seenM = r ? 1'b0 : (seenM | e.illegal);
      #1 chk("rnd_seen", 32'(IllegalSeen), 32'(seenM));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
